// File: rtl/mult_share_arb.sv
// mult_share_arb
//
// Shares one shift-add multiplier between two requesters. An idle arbiter
// grants one eligible requester, captures its operands and runs WIDTH
// shift-add steps. It then presents the product with a one-cycle done pulse
// tagged with the owner.
//
// A requester is eligible while its req is high and it has not just been
// served. It has to drop req for at least one cycle before it can be
// granted again. A tie goes to the requester that was not served last.
//
// Optional build macro:
//   MULT_ARB_FIXED_PRIO_EN - requester 0 always wins a tie and there is no
//                            last-owner tracking. Requester 1 may starve.
//
// Ports:
//   clk            system clock, rising edge
//   reset          asynchronous, active-high reset
//   req0/a0/b0     requester 0: level request, multiplicand, multiplier
//   req1/a1/b1     requester 1: level request, multiplicand, multiplier
//   gnt0/gnt1      the requester that currently owns the multiplier
//   busy           operation in progress (CALC or DONE)
//   done           one-cycle pulse while product is fresh
//   owner          id of the last granted requester
//   product        last completed a*b; held until the next done
//
// The design assumes WIDTH >= 2.
module mult_share_arb #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req0,
    input  logic [WIDTH-1:0]   a0,
    input  logic [WIDTH-1:0]   b0,
    input  logic               req1,
    input  logic [WIDTH-1:0]   a1,
    input  logic [WIDTH-1:0]   b1,
    output logic               gnt0,
    output logic               gnt1,
    output logic               busy,
    output logic               done,
    output logic               owner,
    output logic [2*WIDTH-1:0] product
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH:0]   acc;
    logic [2*WIDTH:0]   acc_step;
    logic [WIDTH:0]     acc_hi_sum;
    logic [CNT_W-1:0]   cnt;
    logic               served0;
    logic               served1;
    logic               elig0;
    logic               elig1;
    logic               tie_winner;
    logic               grant_go;
    logic               grant_id;
    logic               last_step;

    assign elig0     = req0 & ~served0;
    assign elig1     = req1 & ~served1;
    assign last_step = (state == CALC) && (cnt == LAST_STEP);

`ifdef MULT_ARB_FIXED_PRIO_EN
    assign tie_winner = 1'b0;
`else
    // Requester served most recently; starts at 1 so requester 0 wins the
    // first tie after reset.
    logic last_owner;

    assign tie_winner = ~last_owner;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_owner <= 1'b1;
        end else if (last_step) begin
            last_owner <= owner;
        end
    end
`endif

    // One shift-add step: conditionally add the multiplicand into the upper
    // half, whose extra MSB absorbs the carry, then shift the whole
    // accumulator right. The multiplier bits drain out of the low end while
    // product bits fill in from the top.
    assign acc_hi_sum = acc[0] ? (acc[2*WIDTH:WIDTH] + {1'b0, mcand})
                               : acc[2*WIDTH:WIDTH];
    assign acc_step   = {1'b0, acc_hi_sum, acc[WIDTH-1:1]};

    // Arbitration is evaluated only in IDLE; requests seen during CALC or
    // DONE wait for the return to IDLE.
    always_comb begin
        state_nxt = state;
        grant_go  = 1'b0;
        grant_id  = 1'b0;
        case (state)
            IDLE: begin
                if (elig0 | elig1) begin
                    grant_go  = 1'b1;
                    grant_id  = (elig0 & elig1) ? tie_winner : elig1;
                    state_nxt = CALC;
                end
            end
            CALC: begin
                if (cnt == LAST_STEP) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Control state. A reset in the middle of CALC simply returns here to
    // IDLE, so the aborted operation never reaches DONE or touches product.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            owner   <= 1'b0;
            served0 <= 1'b0;
            served1 <= 1'b0;
            product <= '0;
        end else begin
            state <= state_nxt;
            if (grant_go) begin
                owner <= grant_id;
            end
            if (last_step) begin
                product <= acc_step[2*WIDTH-1:0];
            end
            // Set when the owner completes; any cycle with req low clears it.
            served0 <= req0 & (served0 | ((state == DONE) && (owner == 1'b0)));
            served1 <= req1 & (served1 | ((state == DONE) && (owner == 1'b1)));
        end
    end

    // Datapath registers: only meaningful between a grant and its done.
    always_ff @(posedge clk) begin
        if (grant_go) begin
            mcand <= grant_id ? a1 : a0;
            acc   <= {{(WIDTH + 1){1'b0}}, (grant_id ? b1 : b0)};
            cnt   <= '0;
        end else if (state == CALC) begin
            acc <= acc_step;
            cnt <= cnt + 1'b1;
        end
    end

    // Grants are decoded from one owner bit, so they can never overlap.
    assign busy = (state != IDLE);
    assign done = (state == DONE);
    assign gnt0 = busy & ~owner;
    assign gnt1 = busy & owner;

endmodule

// File: tb/tb_mult_share_arb.sv
module tb_mult_share_arb;

    localparam int W = 4;
`ifdef MULT_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic           clk;
    logic           reset;
    logic           req0;
    logic [W-1:0]   a0;
    logic [W-1:0]   b0;
    logic           req1;
    logic [W-1:0]   a1;
    logic [W-1:0]   b1;
    logic           gnt0;
    logic           gnt1;
    logic           busy;
    logic           done;
    logic           owner;
    logic [2*W-1:0] product;

    int errors = 0;
    int checks = 0;

    mult_share_arb #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .req0    (req0),
        .a0      (a0),
        .b0      (b0),
        .req1    (req1),
        .a1      (a1),
        .b1      (b1),
        .gnt0    (gnt0),
        .gnt1    (gnt1),
        .busy    (busy),
        .done    (done),
        .owner   (owner),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit           who;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [2*W-1:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference rules: plain product, and the arbitration choice.
    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        int unsigned p;
        p = int'(a) * int'(b);
        return p[2*W-1:0];
    endfunction

    function automatic bit ref_pick(input bit e0, input bit e1, input bit last);
        if (e0 && e1) return FIXED ? 1'b0 : !last;
        return e1 && !e0;
    endfunction

    // Waits (bounded) for done; cyc = negedges waited.
    task automatic wait_done(input string name, output int cyc);
        cyc = 0;
        while (done !== 1'b1 && cyc < 30) begin
            @(negedge clk);
            cyc++;
            check({name, "_gnt_excl"}, {31'b0, gnt0 & gnt1}, 32'd0);
        end
        check({name, "_done_seen"}, {31'b0, done}, 32'd1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        vec_t tbl[5];
        int   cyc;
        bit   last_m;
        bit   exp_own;
        bit   saw_done;
        logic [2*W-1:0] exp_p;

        tbl[0] = '{1'b0, 4'd3,  4'd5,  8'h0F};
        tbl[1] = '{1'b1, 4'd15, 4'd15, 8'hE1};
        tbl[2] = '{1'b0, 4'd0,  4'd9,  8'h00};
        tbl[3] = '{1'b1, 4'd7,  4'd6,  8'h2A};
        tbl[4] = '{1'b0, 4'd15, 4'd1,  8'h0F};

        // Reset state
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        #12;
        check("rst_gnt0", {31'b0, gnt0}, 32'd0);
        check("rst_gnt1", {31'b0, gnt1}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_owner", {31'b0, owner}, 32'd0);
        check("rst_product", {24'b0, product}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Table: single operations, operands scrambled and req dropped after grant
        for (int i = 0; i < 5; i++) begin
            if (tbl[i].who == 1'b0) begin
                req0 = 1'b1; a0 = tbl[i].a; b0 = tbl[i].b;
            end else begin
                req1 = 1'b1; a1 = tbl[i].a; b1 = tbl[i].b;
            end
            @(negedge clk);
            check($sformatf("t%0d_gnt0", i), {31'b0, gnt0}, {31'b0, !tbl[i].who});
            check($sformatf("t%0d_gnt1", i), {31'b0, gnt1}, {31'b0, tbl[i].who});
            check($sformatf("t%0d_busy", i), {31'b0, busy}, 32'd1);
            check($sformatf("t%0d_owner", i), {31'b0, owner}, {31'b0, tbl[i].who});
            req0 = 1'b0; req1 = 1'b0;
            a0 = ~tbl[i].a; b0 = ~tbl[i].b; a1 = ~tbl[i].a; b1 = ~tbl[i].b;
            for (int k = 1; k < W; k++) begin
                @(negedge clk);
                check($sformatf("t%0d_early_done%0d", i, k), {31'b0, done}, 32'd0);
            end
            @(negedge clk);
            check($sformatf("t%0d_done", i), {31'b0, done}, 32'd1);
            check($sformatf("t%0d_product", i), {24'b0, product}, {24'b0, tbl[i].exp});
            check($sformatf("t%0d_done_owner", i), {31'b0, owner}, {31'b0, tbl[i].who});
            @(negedge clk);
            check($sformatf("t%0d_done_fall", i), {31'b0, done}, 32'd0);
            check($sformatf("t%0d_busy_fall", i), {31'b0, busy}, 32'd0);
            check($sformatf("t%0d_gnt_fall", i), {31'b0, gnt0 | gnt1}, 32'd0);
            check($sformatf("t%0d_product_hold", i), {24'b0, product}, {24'b0, tbl[i].exp});
            @(negedge clk);
        end

        // Continuous contention with one-cycle drop after each done
        do_reset();
        last_m = 1'b1;
        req0 = 1'b1; a0 = 4'd5; b0 = 4'd6;
        req1 = 1'b1; a1 = 4'd9; b1 = 4'd3;
        for (int n = 0; n < 4; n++) begin
            exp_own = ref_pick(1'b1, 1'b1, last_m);
            exp_p   = exp_own ? ref_mul(a1, b1) : ref_mul(a0, b0);
            wait_done($sformatf("rr%0d", n), cyc);
            check($sformatf("rr%0d_latency", n), cyc, W + 1);
            check($sformatf("rr%0d_owner", n), {31'b0, owner}, {31'b0, exp_own});
            check($sformatf("rr%0d_product", n), {24'b0, product}, {24'b0, exp_p});
            last_m = exp_own;
            if (exp_own) req1 = 1'b0; else req0 = 1'b0;
            @(negedge clk);
            if (exp_own) begin req1 = 1'b1; a1 = a1 + 4'd1; end
            else begin req0 = 1'b1; a0 = a0 + 4'd2; end
        end
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);

        // Held request is not regranted until it drops for a cycle
        do_reset();
        req0 = 1'b1; a0 = 4'd2; b0 = 4'd7;
        wait_done("hold_first", cyc);
        check("hold_first_product", {24'b0, product}, 32'd14);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check($sformatf("hold_no_regrant%0d", k), {31'b0, gnt0 | busy}, 32'd0);
        end
        req0 = 1'b0;
        @(negedge clk);
        req0 = 1'b1; a0 = 4'd4; b0 = 4'd4;
        @(negedge clk);
        check("hold_regrant", {31'b0, gnt0}, 32'd1);
        wait_done("hold_second", cyc);
        check("hold_second_product", {24'b0, product}, 32'd16);
        req0 = 1'b0;
        @(negedge clk);

        // Reset in the middle of CALC
        do_reset();
        req1 = 1'b1; a1 = 4'd7; b1 = 4'd6;
        @(negedge clk);
        check("abort_gnt1", {31'b0, gnt1}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_gnt1_rst", {31'b0, gnt1}, 32'd0);
        check("abort_busy_rst", {31'b0, busy}, 32'd0);
        check("abort_done_rst", {31'b0, done}, 32'd0);
        check("abort_owner_rst", {31'b0, owner}, 32'd0);
        check("abort_product_rst", {24'b0, product}, 32'd0);
        @(negedge clk);
        reset = 1'b0; req1 = 1'b0;
        saw_done = 1'b0;
        for (int k = 0; k < W + 3; k++) begin
            @(negedge clk);
            if (done === 1'b1) saw_done = 1'b1;
        end
        check("abort_no_done", {31'b0, saw_done}, 32'd0);
        check("abort_product_kept", {24'b0, product}, 32'd0);

        // Random rounds against the reference rules
        do_reset();
        last_m = 1'b1;
        for (int n = 0; n < 30; n++) begin
            int   m;
            m = int'($urandom_range(1, 3));
            a0 = W'($urandom); b0 = W'($urandom);
            a1 = W'($urandom); b1 = W'($urandom);
            req0 = m[0]; req1 = m[1];
            exp_own = ref_pick(m[0], m[1], last_m);
            exp_p   = exp_own ? ref_mul(a1, b1) : ref_mul(a0, b0);
            wait_done($sformatf("rnd%0d", n), cyc);
            check($sformatf("rnd%0d_latency", n), cyc, W + 1);
            check($sformatf("rnd%0d_owner", n), {31'b0, owner}, {31'b0, exp_own});
            check($sformatf("rnd%0d_gnt1", n), {31'b0, gnt1}, {31'b0, exp_own});
            check($sformatf("rnd%0d_product", n), {24'b0, product}, {24'b0, exp_p});
            last_m = exp_own;
            req0 = 1'b0; req1 = 1'b0;
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mult_share_arb.md
# mult_share_arb

Arbitrates two requesters for one shared shift-add multiplier and runs the multiply it grants. A requester raises its request with its operands. The block grants one requester, captures that requester's operands and runs the shift-add sequence for WIDTH cycles. It then returns the product with a one-cycle done pulse tagged with the owner. It sits between the button/operand front-end logic and the display path.

## Interface
- WIDTH, default 4: operand width in bits; the product is 2*WIDTH bits wide.
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  reset, asynchronous, active-high.
- req0  input  1  request from requester 0; level signal.
- a0  input  WIDTH  multiplicand from requester 0.
- b0  input  WIDTH  multiplier from requester 0.
- req1  input  1  request from requester 1; level signal.
- a1  input  WIDTH  multiplicand from requester 1.
- b1  input  WIDTH  multiplier from requester 1.
- gnt0  output  1  requester 0 owns the multiplier.
- gnt1  output  1  requester 1 owns the multiplier.
- busy  output  1  an operation is in progress (state CALC or DONE).
- done  output  1  one-cycle pulse; product is valid.
- owner  output  1  id of the last granted requester.
- product  output  2*WIDTH  result of the last completed operation; held until the next done.

## Operation
- States: IDLE, CALC, DONE.
- Eligibility: requester i is eligible when req_i=1 and served_i=0.
- served_i is set on the DONE cycle for the owner. It clears on any edge where req_i=0.
- A requester must drop req for at least one cycle before it can be granted again.
- IDLE, no eligible requester: stay in IDLE.
- IDLE, one eligible requester: grant it.
- IDLE, both eligible: grant the requester not equal to last_owner (round-robin).
- On the grant edge:
  - mcand <= a_i.
  - acc[2W:0] <= {(W+1)'b0, b_i}.
  - cnt <= 0, owner <= i, gnt_i <= 1, state <= CALC.
- Operand changes after the grant edge are ignored.
- CALC, each edge:
  - If acc[0]=1: acc[2W:W] <= acc[2W:W] + mcand. The extra MSB absorbs the carry.
  - Then shift right by 1 (combined into a single update).
  - cnt <= cnt+1.
- When cnt reaches WIDTH-1 on an edge: product <= final acc[2W-1:0], done <= 1, state <= DONE, last_owner <= owner.
- DONE, next edge: done <= 0, gnt <= 0, state <= IDLE. No arbitration happens in the DONE cycle.
- Arithmetic is unsigned. product is exactly a*b with no overflow possible.
- Reset values: gnt0=0, gnt1=0, busy=0, done=0, owner=0, product=0, state=IDLE, served=0, last_owner=1 (requester 0 wins the first tie).
- Reset asserted mid-CALC: the operation is aborted, no done is produced and product is not updated.
- Dropping req during CALC does not abort the operation; it completes and pulses done.
- The gnt outputs are mutually exclusive at all times.

## Timing
- Edge E0: IDLE sees an eligible request. gnt_i, busy and owner are visible after E0.
- Edges E1..EW: the WIDTH shift-add steps. done and product are visible after EW, for exactly one cycle.
- Edge EW+1: return to IDLE. gnt and busy fall. The earliest next grant is edge EW+2.
- Throughput: one operation every WIDTH+2 cycles under continuous contention.
- Requests arriving during CALC or DONE are sampled only in IDLE.

## Configuration
- MULT_ARB_FIXED_PRIO_EN defined: requester 0 always wins a tie and last_owner is ignored. Starvation of requester 1 is permitted.
- MULT_ARB_FIXED_PRIO_EN undefined (default): round-robin as described in Operation.

## Test plan
- Single operation: WIDTH=4, req0=1, a0=3, b0=5 -> gnt0 after E0, done after E4, product=0x0F, owner=0, then gnt0=0.
- Simultaneous requests after reset: req0 and req1 both held, each dropping req for one cycle after its done -> grant order 0,1,0,1. Each done carries the matching owner and that requester's product.
- Maximum operands: a1=15, b1=15 -> product=0xE1 (225). a0=0, b0=9 -> product=0x00.
- Held request: req0 kept high after its done, req1 low -> no regrant. Drop req0 for one cycle and raise it again -> granted.
- Reset mid-CALC: start a1=7, b1=6, then assert reset after E2 -> all outputs return to reset values, no done pulse, product stays 0.
- MULT_ARB_FIXED_PRIO_EN defined, both requesting continuously with the one-cycle drop -> requester 0 granted on every tie.
